fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 8'd0, is the PC value loaded on reset.
REQ-002 Parameter NOP_WORD, default 16'h0000, is the bubble instruction inserted into the IF/ID register.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  run request; leaves IDLE when high, inserts a bubble when low in RUN.
REQ-006 stall  input  1  hazard hold from decode; freezes PC and IF/ID.
REQ-007 branch_taken  input  1  redirect request from a later stage (jump/branch resolved).
REQ-008 branch_target  input  8  redirect address, valid when branch_taken=1.
REQ-009 imem_addr  output  8  instruction memory address, equal to PC (combinational memory read).
REQ-010 imem_rdata  input  16  instruction word at imem_addr, valid in the same cycle.
REQ-011 id_ir  output  16  IF/ID instruction register.
REQ-012 id_pc  output  8  address the id_ir word was fetched from.
REQ-013 id_valid  output  1  id_ir holds a real fetched instruction (0 = bubble).
REQ-014 halted  output  1  high while the fetch FSM is in HALTED.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN, HALTED; encoding is free.
REQ-016 Priority per edge SHALL be: reset > branch_taken > stall > enable/normal fetch.
REQ-017 IDLE: PC hold, id_ir<=NOP_WORD, id_valid<=0; enable=1 -> RUN with no fetch that cycle; branch_taken and stall ignored.
REQ-018 RUN, normal fetch (branch_taken=0, stall=0, enable=1): id_ir<=imem_rdata, id_pc<=PC, id_valid<=1, PC<=PC+1.
REQ-019 PC increment SHALL be 8-bit modulo: 8'hFF -> 8'h00, no flag.
REQ-020 RUN, branch_taken=1: PC<=branch_target, id_ir<=NOP_WORD, id_valid<=0, id_pc unchanged; applies even if stall=1 or enable=0.
REQ-021 RUN, stall=1, branch_taken=0: PC, id_ir, id_pc, id_valid all hold.
REQ-022 RUN, enable=0, stall=0, branch_taken=0: PC hold, id_ir<=NOP_WORD, id_valid<=0; state stays RUN.
REQ-023 HALT detect: on a normal fetch with imem_rdata[15:11]=5'b00001, id_ir<=imem_rdata, id_pc<=PC, id_valid<=1, PC SHALL NOT increment, state -> HALTED.
REQ-024 HALTED: PC hold, id_ir<=NOP_WORD, id_valid<=0 from the next edge onward; stall and enable ignored.
REQ-025 HALTED, branch_taken=1: PC<=branch_target, id_ir<=NOP_WORD, id_valid<=0, state -> RUN (speculative HALT cancelled).
REQ-026 HALT is only detected on a normal fetch; a HALT word present during stall, branch, or bubble cycles SHALL NOT change state.
REQ-027 imem_addr SHALL equal PC combinationally; no extra latency.
REQ-028 halted SHALL be a registered decode of state HALTED.

Reset
REQ-029 On a clock edge with reset=1: PC<=RESET_PC, id_ir<=NOP_WORD, id_pc<=8'd0, id_valid<=0, state<=IDLE, halted<=0.
REQ-030 Reset asserted mid-RUN or mid-HALTED SHALL override all other inputs on that edge; the pipeline restarts from IDLE.

Verification
REQ-031 Reset, then enable=1 for one cycle with memory word 0 = 16'h0000 and word 1 = 16'h1300 -> imem_addr=0 in IDLE; first RUN edge: id_ir=16'h0000, id_pc=0, imem_addr=1; next edge: id_ir=16'h1300, id_pc=1, id_valid=1.
REQ-032 stall=1 for 2 cycles at PC=5 -> imem_addr stays 5 and id_ir/id_pc/id_valid unchanged for 2 edges; fetch of address 5 resumes on the 3rd edge.
REQ-033 branch_taken=1, branch_target=8'h0B, stall=1 at PC=9 -> next edge: imem_addr=8'h0B, id_ir=16'h0000, id_valid=0.
REQ-034 HALT word 16'h0800 at address 17 -> edge: id_ir=16'h0800, id_pc=17, halted=1, imem_addr=17; following edges: id_ir=16'h0000, id_valid=0; then branch_taken=1 with target 4 -> halted=0, imem_addr=4.
REQ-035 PC=8'hFF, normal fetch -> id_pc=8'hFF, imem_addr=8'h00.
REQ-036 reset=1 asserted during RUN at PC=8'h20 with stall=1 and branch_taken=1 -> imem_addr=RESET_PC, id_valid=0, halted=0, state IDLE; no fetch until enable=1.

Source files
------------

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with PC, IF/ID register and IDLE/RUN/HALTED FSM
// Redirects outrank stalls; a HALT word seen on a normal fetch parks the FSM until reset or a redirect.
module fetch_stage #(
  parameter logic [7:0]  RESET_PC = 8'd0,
  parameter logic [15:0] NOP_WORD = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [7:0]  branch_target,
  output logic [7:0]  imem_addr,
  input  logic [15:0] imem_rdata,
  output logic [15:0] id_ir,
  output logic [7:0]  id_pc,
  output logic        id_valid,
  output logic        halted
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] id_ir_q, id_ir_d;
  logic [7:0]  id_pc_q, id_pc_d;
  logic        id_valid_q, id_valid_d;
  logic        halted_q, halted_d;
  logic        is_halt_word;
  logic        normal_fetch;

  assign is_halt_word = (imem_rdata[15:11] == 5'b00001);
  assign normal_fetch = (state_q == S_RUN) && !branch_taken && !stall && enable;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      id_ir_q    <= NOP_WORD;
      id_pc_q    <= 8'd0;
      id_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_ir_q    <= id_ir_d;
      id_pc_q    <= id_pc_d;
      id_valid_q <= id_valid_d;
      halted_q   <= halted_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (enable) state_d = S_RUN;
      S_RUN:    if (normal_fetch && is_halt_word) state_d = S_HALTED;
      S_HALTED: if (branch_taken) state_d = S_RUN;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    id_ir_d    = id_ir_q;
    id_pc_d    = id_pc_q;
    id_valid_d = id_valid_q;
    case (state_q)
      S_RUN: begin
        if (branch_taken) begin
          pc_d       = branch_target;
          id_ir_d    = NOP_WORD;
          id_valid_d = 1'b0;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (enable) begin
          id_ir_d    = imem_rdata;
          id_pc_d    = pc_q;
          id_valid_d = 1'b1;
          // The HALT word itself is issued, but the PC stays on it.
          pc_d       = is_halt_word ? pc_q : pc_q + 8'd1;
        end else begin
          id_ir_d    = NOP_WORD;
          id_valid_d = 1'b0;
        end
      end
      S_HALTED: begin
        id_ir_d    = NOP_WORD;
        id_valid_d = 1'b0;
        if (branch_taken) pc_d = branch_target;
      end
      default: begin
        id_ir_d    = NOP_WORD;
        id_valid_d = 1'b0;
      end
    endcase
    halted_d = (state_d == S_HALTED);
  end

  assign imem_addr = pc_q;
  assign id_ir     = id_ir_q;
  assign id_pc     = id_pc_q;
  assign id_valid  = id_valid_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed and randomized checks of fetch_stage against a behavioural model
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [7:0]  branch_target = 8'd0;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic [15:0] id_ir;
  logic [7:0]  id_pc;
  logic        id_valid;
  logic        halted;

  logic [15:0] mem [256];
  int n_assert = 0;
  int n_fail = 0;

  int          m_state;
  int          m_pc;
  logic [15:0] m_ir;
  int          m_idpc;
  logic        m_valid;

  localparam int ST_IDLE = 0, ST_RUN = 1, ST_HALT = 2;

  fetch_stage dut (
    .clk(clk), .reset(reset), .enable(enable), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .id_ir(id_ir), .id_pc(id_pc), .id_valid(id_valid), .halted(halted)
  );

  assign imem_rdata = mem[imem_addr];

  always #5 clk = ~clk;

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 | 16'(i);
  endtask

  // Advance one clock; the model follows the priority rules using the word at the model PC.
  task automatic step();
    logic [15:0] w;
    w = mem[m_pc];
    if (reset) begin
      m_state = ST_IDLE; m_pc = 0; m_ir = 16'h0000; m_idpc = 0; m_valid = 1'b0;
    end else if (m_state == ST_IDLE) begin
      m_ir = 16'h0000; m_valid = 1'b0;
      if (enable) m_state = ST_RUN;
    end else if (m_state == ST_RUN) begin
      if (branch_taken) begin
        m_pc = int'(branch_target); m_ir = 16'h0000; m_valid = 1'b0;
      end else if (stall) begin
      end else if (enable) begin
        m_ir = w; m_idpc = m_pc; m_valid = 1'b1;
        if (w[15:11] == 5'd1) m_state = ST_HALT;
        else m_pc = (m_pc + 1) % 256;
      end else begin
        m_ir = 16'h0000; m_valid = 1'b0;
      end
    end else begin
      m_ir = 16'h0000; m_valid = 1'b0;
      if (branch_taken) begin
        m_pc = int'(branch_target); m_state = ST_RUN;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic go_run_at(input logic [7:0] p);
    do_reset();
    enable = 1'b1;
    step();
    branch_taken = 1'b1; branch_target = p;
    step();
    branch_taken = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_assert++;
    if ({imem_addr, id_ir, id_pc, id_valid, halted} !== {8'd0, 16'h0000, 8'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got addr=%h ir=%h pc=%h v=%b h=%b, want 00 0000 00 0 0",
               imem_addr, id_ir, id_pc, id_valid, halted);
    end
  endtask

  task automatic test_first_fetch();
    fill_mem();
    mem[0] = 16'h0000; mem[1] = 16'h1300;
    do_reset();
    enable = 1'b1;
    step();
    n_assert++;
    if (imem_addr !== 8'd0 || id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_fetch: got addr=%h v=%b, want 00 0", imem_addr, id_valid);
    end
    step();
    n_assert++;
    if ({id_ir, id_pc, imem_addr, id_valid} !== {16'h0000, 8'd0, 8'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL first_fetch: got ir=%h pc=%h addr=%h v=%b, want 0000 00 01 1", id_ir, id_pc, imem_addr, id_valid);
    end
    step();
    n_assert++;
    if ({id_ir, id_pc, id_valid} !== {16'h1300, 8'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL second_fetch: got ir=%h pc=%h v=%b, want 1300 01 1", id_ir, id_pc, id_valid);
    end
  endtask

  task automatic test_stall();
    fill_mem();
    go_run_at(8'd4);
    step();
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      n_assert++;
      if ({imem_addr, id_ir, id_pc, id_valid} !== {8'd5, 16'h1004, 8'd4, 1'b1}) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got addr=%h ir=%h pc=%h v=%b, want 05 1004 04 1",
                 k, imem_addr, id_ir, id_pc, id_valid);
      end
    end
    stall = 1'b0;
    step();
    n_assert++;
    if ({imem_addr, id_ir, id_pc, id_valid} !== {8'd6, 16'h1005, 8'd5, 1'b1}) begin
      n_fail++;
      $display("FAIL stall_resume: got addr=%h ir=%h pc=%h v=%b, want 06 1005 05 1", imem_addr, id_ir, id_pc, id_valid);
    end
  endtask

  task automatic test_branch_over_stall();
    fill_mem();
    go_run_at(8'd9);
    stall = 1'b1; branch_taken = 1'b1; branch_target = 8'h0B;
    step();
    stall = 1'b0; branch_taken = 1'b0;
    n_assert++;
    if ({imem_addr, id_ir, id_valid} !== {8'h0B, 16'h0000, 1'b0}) begin
      n_fail++;
      $display("FAIL branch_over_stall: got addr=%h ir=%h v=%b, want 0b 0000 0", imem_addr, id_ir, id_valid);
    end
  endtask

  task automatic test_halt();
    fill_mem();
    mem[17] = 16'h0800;
    mem[30] = 16'h0800;
    go_run_at(8'd30);
    stall = 1'b1;
    step();
    step();
    stall = 1'b0;
    n_assert++;
    if (halted !== 1'b0 || imem_addr !== 8'd30) begin
      n_fail++;
      $display("FAIL halt_during_stall: got h=%b addr=%h, want 0 1e", halted, imem_addr);
    end
    go_run_at(8'd17);
    step();
    n_assert++;
    if ({id_ir, id_pc, halted, imem_addr, id_valid} !== {16'h0800, 8'd17, 1'b1, 8'd17, 1'b1}) begin
      n_fail++;
      $display("FAIL halt_fetch: got ir=%h pc=%h h=%b addr=%h v=%b, want 0800 11 1 11 1",
               id_ir, id_pc, halted, imem_addr, id_valid);
    end
    stall = 1'b1;
    step();
    stall = 1'b0;
    step();
    n_assert++;
    if ({id_ir, id_valid, halted, imem_addr} !== {16'h0000, 1'b0, 1'b1, 8'd17}) begin
      n_fail++;
      $display("FAIL halted_bubble: got ir=%h v=%b h=%b addr=%h, want 0000 0 1 11", id_ir, id_valid, halted, imem_addr);
    end
    branch_taken = 1'b1; branch_target = 8'd4;
    step();
    branch_taken = 1'b0;
    n_assert++;
    if ({halted, imem_addr, id_valid} !== {1'b0, 8'd4, 1'b0}) begin
      n_fail++;
      $display("FAIL halt_cancel: got h=%b addr=%h v=%b, want 0 04 0", halted, imem_addr, id_valid);
    end
    step();
    n_assert++;
    if ({id_ir, id_pc, id_valid, imem_addr} !== {16'h1004, 8'd4, 1'b1, 8'd5}) begin
      n_fail++;
      $display("FAIL fetch_after_cancel: got ir=%h pc=%h v=%b addr=%h, want 1004 04 1 05", id_ir, id_pc, id_valid, imem_addr);
    end
  endtask

  task automatic test_bubble();
    fill_mem();
    go_run_at(8'd40);
    step();
    enable = 1'b0;
    step();
    n_assert++;
    if ({imem_addr, id_ir, id_valid, halted} !== {8'd41, 16'h0000, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL bubble: got addr=%h ir=%h v=%b h=%b, want 29 0000 0 0", imem_addr, id_ir, id_valid, halted);
    end
    enable = 1'b1;
    step();
    n_assert++;
    if ({id_ir, id_pc, id_valid} !== {16'h1029, 8'd41, 1'b1}) begin
      n_fail++;
      $display("FAIL bubble_resume: got ir=%h pc=%h v=%b, want 1029 29 1", id_ir, id_pc, id_valid);
    end
  endtask

  task automatic test_wrap();
    fill_mem();
    go_run_at(8'hFF);
    step();
    n_assert++;
    if ({id_pc, imem_addr, id_ir} !== {8'hFF, 8'h00, 16'h10FF}) begin
      n_fail++;
      $display("FAIL pc_wrap: got pc=%h addr=%h ir=%h, want ff 00 10ff", id_pc, imem_addr, id_ir);
    end
  endtask

  task automatic test_reset_mid_run();
    fill_mem();
    go_run_at(8'h20);
    step();
    reset = 1'b1; stall = 1'b1; branch_taken = 1'b1; branch_target = 8'h55;
    step();
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; enable = 1'b0;
    n_assert++;
    if ({imem_addr, id_valid, halted, id_pc} !== {8'd0, 1'b0, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL reset_mid_run: got addr=%h v=%b h=%b pc=%h, want 00 0 0 00", imem_addr, id_valid, halted, id_pc);
    end
    step(); step();
    branch_taken = 1'b1; branch_target = 8'h33;
    step();
    branch_taken = 1'b0;
    enable = 1'b1;
    step();
    n_assert++;
    if ({imem_addr, id_valid} !== {8'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL idle_after_reset: got addr=%h v=%b, want 00 0", imem_addr, id_valid);
    end
    step();
    n_assert++;
    if ({imem_addr, id_valid, id_ir} !== {8'd1, 1'b1, 16'h1000}) begin
      n_fail++;
      $display("FAIL restart_fetch: got addr=%h v=%b ir=%h, want 01 1 1000", imem_addr, id_valid, id_ir);
    end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(0, 7) == 0) ? (16'h0800 | 16'($urandom_range(0, 2047)))
                                           : 16'($urandom);
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      reset         = ($urandom_range(0, 99) == 0);
      enable        = ($urandom_range(0, 9) != 0);
      stall         = ($urandom_range(0, 4) == 0);
      branch_taken  = ($urandom_range(0, 9) == 0);
      branch_target = 8'($urandom);
      step();
      n_assert++;
      if ({imem_addr, id_ir, id_pc, id_valid, halted} !==
          {8'(m_pc), m_ir, 8'(m_idpc), m_valid, (m_state == ST_HALT)}) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL random_cycle%0d: got addr=%h ir=%h pc=%h v=%b h=%b, want %h %h %h %b %b",
                   c, imem_addr, id_ir, id_pc, id_valid, halted,
                   8'(m_pc), m_ir, 8'(m_idpc), m_valid, (m_state == ST_HALT));
      end
    end
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0;
  endtask

  initial begin
    fill_mem();
    m_state = ST_IDLE; m_pc = 0; m_ir = 16'h0000; m_idpc = 0; m_valid = 1'b0;
    test_reset();
    test_first_fetch();
    test_stall();
    test_branch_over_stall();
    test_halt();
    test_bubble();
    test_wrap();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
